// File: rtl/spu_lbuf_pkg.sv
`default_nettype none
// ============================================================================
// Module     : spu_lbuf_pkg
// Description: Shared definitions for the SPU line-buffer responder.
//              - Source tags carried down the read pipeline so each result
//                is returned to the port that asked for it.
//              - Legal read-latency range and a helper to check it.
// Revision   : 1.0 - initial release
// ============================================================================
package spu_lbuf_pkg;

   // Read-pipeline source tags
   localparam logic SRC_SPU = 1'b0;
   localparam logic SRC_EXT = 1'b1;

   // Supported read latency range (cycles from request edge to data)
   localparam int RLATENCY_MIN = 1;
   localparam int RLATENCY_MAX = 4;

   function automatic bit rlatency_ok(input int rl);
      return (rl >= RLATENCY_MIN) && (rl <= RLATENCY_MAX);
   endfunction

endpackage
`default_nettype wire

// File: rtl/spu_lbuf_rd_pipe.sv
`default_nettype none
// ============================================================================
// Module     : spu_lbuf_rd_pipe
// Description: Fixed-length shift pipeline of {valid, src, data} used to
//              delay read results by exactly STAGES cycles.
//              The clear input wipes the valid and tag bits synchronously so
//              any read in flight is discarded; data bits are not cleared
//              since they are never observed without their valid.
// Ports      : clk       - clock, rising edge
//              clr       - synchronous clear of valid/src bits
//              in_valid  - a read was accepted this cycle
//              in_src    - source tag of that read
//              in_data   - word read from storage
//              out_valid - result valid, STAGES cycles after in_valid
//              out_src   - source tag of the result
//              out_data  - result word
// Revision   : 1.0 - initial release
// ============================================================================
module spu_lbuf_rd_pipe #(
   parameter int STAGES     = 1,
   parameter int DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  clr,
   input  logic                  in_valid,
   input  logic                  in_src,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic                  out_valid,
   output logic                  out_src,
   output logic [DATA_WIDTH-1:0] out_data
);

   logic [STAGES-1:0]     valid_sr;
   logic [STAGES-1:0]     src_sr;
   logic [DATA_WIDTH-1:0] data_sr [STAGES];

   always_ff @(posedge clk) begin
      if (clr) begin
         valid_sr <= '0;
         src_sr   <= '0;
      end else begin
         valid_sr[0] <= in_valid;
         src_sr[0]   <= in_src;
         for (int i = 1; i < STAGES; i++) begin
            valid_sr[i] <= valid_sr[i-1];
            src_sr[i]   <= src_sr[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      data_sr[0] <= in_data;
      for (int i = 1; i < STAGES; i++) begin
         data_sr[i] <= data_sr[i-1];
      end
   end

   assign out_valid = valid_sr[STAGES-1];
   assign out_src   = src_sr[STAGES-1];
   assign out_data  = data_sr[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/spu_lbuf_resp.sv
`default_nettype none
// ============================================================================
// Module     : spu_lbuf_resp
// Description: Responder side of the SPU line-buffer interface. A single
//              DEPTH x DATA_WIDTH array with one read slot and one write slot
//              per cycle. The SPU port owns both slots when it uses them; the
//              ext (DMA) port fills whichever slot the SPU leaves idle.
//              Reads return after exactly RLATENCY cycles; same-address
//              read/write in one cycle is read-first. Out-of-range accesses
//              drop writes, return zero for reads and raise a sticky error.
// Ports      : core_clk              - clock, rising edge
//              rst                   - synchronous active-high reset
//              lbuf_ren/raddr        - SPU read request / address
//              lbuf_rdata/rvalid     - SPU read result
//              lbuf_wen/waddr/wdata  - SPU write request
//              ext_req/we/addr/wdata - ext access request (we=1 write)
//              ext_gnt               - ext request accepted this cycle
//              ext_rdata/rvalid      - ext read result
//              oor_err               - sticky out-of-range flag
//              err_clr               - clears oor_err (a new error wins)
// Revision   : 1.0 - initial release
// ============================================================================
module spu_lbuf_resp
   import spu_lbuf_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int RLATENCY   = 1
) (
   input  logic                  core_clk,
   input  logic                  rst,
   input  logic                  lbuf_ren,
   input  logic [ADDR_WIDTH-1:0] lbuf_raddr,
   output logic [DATA_WIDTH-1:0] lbuf_rdata,
   output logic                  lbuf_rvalid,
   input  logic                  lbuf_wen,
   input  logic [ADDR_WIDTH-1:0] lbuf_waddr,
   input  logic [DATA_WIDTH-1:0] lbuf_wdata,
   input  logic                  ext_req,
   input  logic                  ext_we,
   input  logic [ADDR_WIDTH-1:0] ext_addr,
   input  logic [DATA_WIDTH-1:0] ext_wdata,
   output logic                  ext_gnt,
   output logic [DATA_WIDTH-1:0] ext_rdata,
   output logic                  ext_rvalid,
   output logic                  oor_err,
   input  logic                  err_clr
);

   // Index width of the storage array; addresses below DEPTH always fit.
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // DEPTH widened by one bit so DEPTH == 2**ADDR_WIDTH is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);

   generate
      if (!rlatency_ok(RLATENCY)) begin : g_bad_rlatency
         $error("spu_lbuf_resp: RLATENCY must be within 1..4");
      end
      if ((DEPTH < 1) || (DEPTH > (1 << ADDR_WIDTH))) begin : g_bad_depth
         $error("spu_lbuf_resp: DEPTH must be within 1..2**ADDR_WIDTH");
      end
   endgenerate

   // ------------------------------------------------------------------
   // Slot arbitration. Everything is qualified with ~rst so that nothing
   // presented during reset reaches storage, the pipeline or the error
   // flag, and the ext requester is not told it was served.
   // ------------------------------------------------------------------
   logic                  ext_rd_req;
   logic                  ext_wr_req;
   logic                  rd_take;
   logic                  rd_src;
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_oor;
   logic                  wr_take;
   logic [ADDR_WIDTH-1:0] wr_addr;
   logic [DATA_WIDTH-1:0] wr_data;
   logic                  wr_oor;

   assign ext_rd_req = ext_req & ~ext_we;
   assign ext_wr_req = ext_req &  ext_we;

   assign ext_gnt = ~rst & ext_req & (ext_we ? ~lbuf_wen : ~lbuf_ren);

   assign rd_take = ~rst & (lbuf_ren | ext_rd_req);
   assign rd_src  = lbuf_ren ? SRC_SPU : SRC_EXT;
   assign rd_addr = lbuf_ren ? lbuf_raddr : ext_addr;
   assign rd_oor  = ({1'b0, rd_addr} >= DEPTH_LIM);

   assign wr_take = ~rst & (lbuf_wen | ext_wr_req);
   assign wr_addr = lbuf_wen ? lbuf_waddr : ext_addr;
   assign wr_data = lbuf_wen ? lbuf_wdata : ext_wdata;
   assign wr_oor  = ({1'b0, wr_addr} >= DEPTH_LIM);

   // ------------------------------------------------------------------
   // Storage. The read below samples the old contents at the same edge
   // the write lands, which gives read-first collision behaviour.
   // ------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] mem [DEPTH];
   logic [DATA_WIDTH-1:0] rd_word;

   always_ff @(posedge core_clk) begin
      if (wr_take && !wr_oor) begin
         mem[wr_addr[IDX_W-1:0]] <= wr_data;
      end
   end

   assign rd_word = rd_oor ? '0 : mem[rd_addr[IDX_W-1:0]];

   // ------------------------------------------------------------------
   // Read pipeline: first stage captures the storage word at the request
   // edge, the remaining RLATENCY-1 stages only delay it.
   // ------------------------------------------------------------------
   logic                  pipe_valid;
   logic                  pipe_src;
   logic [DATA_WIDTH-1:0] pipe_data;

   spu_lbuf_rd_pipe #(
      .STAGES     (RLATENCY),
      .DATA_WIDTH (DATA_WIDTH)
   ) u_rd_pipe (
      .clk       (core_clk),
      .clr       (rst),
      .in_valid  (rd_take),
      .in_src    (rd_src),
      .in_data   (rd_word),
      .out_valid (pipe_valid),
      .out_src   (pipe_src),
      .out_data  (pipe_data)
   );

   // Per-port result steering. Each port shows the pipeline word only on
   // its own valid cycle and otherwise its last own result, so a port
   // never sees data meant for the other one.
   logic [DATA_WIDTH-1:0] lbuf_hold;
   logic [DATA_WIDTH-1:0] ext_hold;

   assign lbuf_rvalid = pipe_valid & (pipe_src == SRC_SPU);
   assign ext_rvalid  = pipe_valid & (pipe_src == SRC_EXT);

   always_ff @(posedge core_clk) begin
      if (rst) begin
         lbuf_hold <= '0;
         ext_hold  <= '0;
      end else begin
         if (lbuf_rvalid) lbuf_hold <= pipe_data;
         if (ext_rvalid)  ext_hold  <= pipe_data;
      end
   end

   assign lbuf_rdata = lbuf_rvalid ? pipe_data : lbuf_hold;
   assign ext_rdata  = ext_rvalid  ? pipe_data : ext_hold;

   // ------------------------------------------------------------------
   // Sticky out-of-range flag; a new violation beats a same-cycle clear.
   // ------------------------------------------------------------------
   logic oor_flag;

   always_ff @(posedge core_clk) begin
      if (rst) begin
         oor_flag <= 1'b0;
      end else if ((rd_take && rd_oor) || (wr_take && wr_oor)) begin
         oor_flag <= 1'b1;
      end else if (err_clr) begin
         oor_flag <= 1'b0;
      end
   end

   assign oor_err = oor_flag;

endmodule
`default_nettype wire

// File: tb/tb_spu_lbuf_resp.sv
`default_nettype none
// ============================================================================
// Module     : tb_spu_lbuf_resp
// Description: Directed, self-checking bench for spu_lbuf_resp. Two
//              instances (RLATENCY 1 and 3, both DEPTH 1024) see the same
//              stimulus; expected read data and valid timing are written
//              out by hand for each latency.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_spu_lbuf_resp;

   logic        clk = 1'b0;
   logic        rst;
   logic        lbuf_ren;
   logic [11:0] lbuf_raddr;
   logic        lbuf_wen;
   logic [11:0] lbuf_waddr;
   logic [31:0] lbuf_wdata;
   logic        ext_req;
   logic        ext_we;
   logic [11:0] ext_addr;
   logic [31:0] ext_wdata;
   logic        err_clr;

   logic [31:0] a_lbuf_rdata, a_ext_rdata, b_lbuf_rdata, b_ext_rdata;
   logic        a_lbuf_rvalid, a_ext_rvalid, b_lbuf_rvalid, b_ext_rvalid;
   logic        a_ext_gnt, b_ext_gnt, a_oor, b_oor;

   int n_cmp  = 0;
   int n_fail = 0;

   // last result each port of each instance is expected to hold
   logic [31:0] ha_s, ha_e, hb_s, hb_e;

   always #5 clk = ~clk;

   spu_lbuf_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .RLATENCY(1)) u_rl1 (
      .core_clk(clk), .rst(rst),
      .lbuf_ren(lbuf_ren), .lbuf_raddr(lbuf_raddr),
      .lbuf_rdata(a_lbuf_rdata), .lbuf_rvalid(a_lbuf_rvalid),
      .lbuf_wen(lbuf_wen), .lbuf_waddr(lbuf_waddr), .lbuf_wdata(lbuf_wdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(a_ext_gnt), .ext_rdata(a_ext_rdata), .ext_rvalid(a_ext_rvalid),
      .oor_err(a_oor), .err_clr(err_clr)
   );

   spu_lbuf_resp #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .DEPTH(1024), .RLATENCY(3)) u_rl3 (
      .core_clk(clk), .rst(rst),
      .lbuf_ren(lbuf_ren), .lbuf_raddr(lbuf_raddr),
      .lbuf_rdata(b_lbuf_rdata), .lbuf_rvalid(b_lbuf_rvalid),
      .lbuf_wen(lbuf_wen), .lbuf_waddr(lbuf_waddr), .lbuf_wdata(lbuf_wdata),
      .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
      .ext_gnt(b_ext_gnt), .ext_rdata(b_ext_rdata), .ext_rvalid(b_ext_rvalid),
      .oor_err(b_oor), .err_clr(err_clr)
   );

   typedef struct {
      bit          is_ext;
      bit          is_wr;
      logic [11:0] addr;
      logic [31:0] data;   // write data, or expected read data
   } vec_t;

   vec_t vecs[15];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      lbuf_ren = 1'b0; lbuf_raddr = '0;
      lbuf_wen = 1'b0; lbuf_waddr = '0; lbuf_wdata = '0;
      ext_req  = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
      err_clr  = 1'b0;
   endtask

   // Check all read outputs of both instances for the current cycle.
   task automatic expect_out(input string tag, input bit a_s, input bit a_e,
                             input bit b_s, input bit b_e,
                             input logic [31:0] da_s, input logic [31:0] da_e,
                             input logic [31:0] db_s, input logic [31:0] db_e);
      if (a_s) ha_s = da_s;
      if (a_e) ha_e = da_e;
      if (b_s) hb_s = db_s;
      if (b_e) hb_e = db_e;
      chk({tag, " rl1 lbuf_rvalid"}, 32'(a_lbuf_rvalid), 32'(a_s));
      chk({tag, " rl1 ext_rvalid"},  32'(a_ext_rvalid),  32'(a_e));
      chk({tag, " rl1 lbuf_rdata"},  a_lbuf_rdata, ha_s);
      chk({tag, " rl1 ext_rdata"},   a_ext_rdata,  ha_e);
      chk({tag, " rl3 lbuf_rvalid"}, 32'(b_lbuf_rvalid), 32'(b_s));
      chk({tag, " rl3 ext_rvalid"},  32'(b_ext_rvalid),  32'(b_e));
      chk({tag, " rl3 lbuf_rdata"},  b_lbuf_rdata, hb_s);
      chk({tag, " rl3 ext_rdata"},   b_ext_rdata,  hb_e);
   endtask

   task automatic chk_oor(input string tag, input logic exp);
      chk({tag, " rl1 oor_err"}, 32'(a_oor), 32'(exp));
      chk({tag, " rl3 oor_err"}, 32'(b_oor), 32'(exp));
   endtask

   task automatic do_write(input bit is_ext, input logic [11:0] addr,
                           input logic [31:0] data, input string tag);
      if (is_ext) begin
         ext_req = 1'b1; ext_we = 1'b1; ext_addr = addr; ext_wdata = data;
         #1;
         chk({tag, " rl1 ext_gnt"}, 32'(a_ext_gnt), 32'd1);
         chk({tag, " rl3 ext_gnt"}, 32'(b_ext_gnt), 32'd1);
      end else begin
         lbuf_wen = 1'b1; lbuf_waddr = addr; lbuf_wdata = data;
      end
      step();
      idle_inputs();
      expect_out(tag, 0, 0, 0, 0, '0, '0, '0, '0);
   endtask

   // One read request, optionally with an SPU write to the same address in
   // the same cycle; follows the result through both latencies.
   task automatic run_read(input bit is_ext, input logic [11:0] addr,
                           input logic [31:0] exp, input bit coll,
                           input logic [31:0] cdata, input string tag);
      if (is_ext) begin
         ext_req = 1'b1; ext_we = 1'b0; ext_addr = addr;
         #1;
         chk({tag, " rl1 ext_gnt"}, 32'(a_ext_gnt), 32'd1);
         chk({tag, " rl3 ext_gnt"}, 32'(b_ext_gnt), 32'd1);
      end else begin
         lbuf_ren = 1'b1; lbuf_raddr = addr;
      end
      if (coll) begin
         lbuf_wen = 1'b1; lbuf_waddr = addr; lbuf_wdata = cdata;
      end
      for (int k = 1; k <= 4; k++) begin
         step();
         if (k == 1) idle_inputs();
         expect_out($sformatf("%s k%0d", tag, k),
                    !is_ext && k == 1, is_ext && k == 1,
                    !is_ext && k == 3, is_ext && k == 3,
                    exp, exp, exp, exp);
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      idle_inputs();
      rst = 1'b1;
      ha_s = '0; ha_e = '0; hb_s = '0; hb_e = '0;
      step();
      step();
      expect_out("reset", 0, 0, 0, 0, '0, '0, '0, '0);
      chk_oor("reset", 1'b0);
      rst = 1'b0;

      // ---------------- table-driven single accesses ----------------
      vecs[0]  = '{0, 1, 12'd5,    32'hDEADBEEF};
      vecs[1]  = '{0, 0, 12'd5,    32'hDEADBEEF};
      vecs[2]  = '{1, 1, 12'd10,   32'h12345678};
      vecs[3]  = '{1, 0, 12'd10,   32'h12345678};
      vecs[4]  = '{0, 0, 12'd10,   32'h12345678};
      vecs[5]  = '{1, 0, 12'd5,    32'hDEADBEEF};
      vecs[6]  = '{0, 1, 12'd0,    32'h00000010};
      vecs[7]  = '{0, 1, 12'd1,    32'h00000011};
      vecs[8]  = '{1, 1, 12'd2,    32'h00000012};
      vecs[9]  = '{0, 1, 12'd3,    32'h00000013};
      vecs[10] = '{0, 1, 12'd1023, 32'hCAFEF00D};
      vecs[11] = '{1, 0, 12'd1023, 32'hCAFEF00D};
      vecs[12] = '{0, 1, 12'd7,    32'h00005555};
      vecs[13] = '{0, 1, 12'd20,   32'h00002020};
      vecs[14] = '{0, 1, 12'd76,   32'h00007676};
      for (int i = 0; i < 15; i++) begin
         if (vecs[i].is_wr)
            do_write(vecs[i].is_ext, vecs[i].addr, vecs[i].data, $sformatf("vec%0d", i));
         else
            run_read(vecs[i].is_ext, vecs[i].addr, vecs[i].data, 1'b0, '0, $sformatf("vec%0d", i));
      end
      chk_oor("in-range table", 1'b0);

      // ---------------- back-to-back reads @0..3 ----------------
      for (int k = 1; k <= 7; k++) begin
         lbuf_ren   = (k <= 4);
         lbuf_raddr = (k <= 4) ? 12'(k - 1) : 12'd0;
         step();
         expect_out($sformatf("b2b k%0d", k),
                    k <= 4, 1'b0, (k >= 3) && (k <= 6), 1'b0,
                    32'h10 + 32'(k - 1), '0, 32'h10 + 32'(k - 3), '0);
      end
      idle_inputs();

      // ---------------- read-first collision ----------------
      run_read(1'b0, 12'd7, 32'h00005555, 1'b1, 32'h0000AAAA, "collide");
      run_read(1'b0, 12'd7, 32'h0000AAAA, 1'b0, '0, "after-collide");

      // ---------------- ext read stalled by SPU reads ----------------
      for (int k = 1; k <= 7; k++) begin
         lbuf_ren = (k <= 3); lbuf_raddr = 12'd5;
         ext_req  = (k <= 4); ext_we = 1'b0; ext_addr = 12'd20;
         #1;
         if (k <= 4) begin
            chk($sformatf("stall k%0d rl1 ext_gnt", k), 32'(a_ext_gnt), 32'(k == 4));
            chk($sformatf("stall k%0d rl3 ext_gnt", k), 32'(b_ext_gnt), 32'(k == 4));
         end
         step();
         expect_out($sformatf("stall k%0d", k),
                    k <= 3, k == 4, (k >= 3) && (k <= 5), k == 6,
                    32'hDEADBEEF, 32'h2020, 32'hDEADBEEF, 32'h2020);
      end
      idle_inputs();

      // ---------------- out-of-range handling ----------------
      do_write(1'b0, 12'd1100, 32'h4C4C4C4C, "oor-wr");
      chk_oor("oor-wr", 1'b1);
      err_clr = 1'b1;
      step();
      idle_inputs();
      chk_oor("err_clr", 1'b0);
      run_read(1'b0, 12'd76, 32'h00007676, 1'b0, '0, "alias-intact");
      chk_oor("alias-intact", 1'b0);
      run_read(1'b0, 12'd1100, 32'h0, 1'b0, '0, "oor-rd");
      chk_oor("oor-rd", 1'b1);
      err_clr = 1'b1; ext_req = 1'b1; ext_we = 1'b1; ext_addr = 12'd2000; ext_wdata = 32'h1;
      step();
      idle_inputs();
      chk_oor("set-wins", 1'b1);
      err_clr = 1'b1;
      step();
      idle_inputs();
      chk_oor("clr-again", 1'b0);
      run_read(1'b1, 12'd1500, 32'h0, 1'b0, '0, "oor-ext-rd");
      chk_oor("oor-ext-rd", 1'b1);

      // ---------------- reset with a read in flight ----------------
      lbuf_ren = 1'b1; lbuf_raddr = 12'd5;
      step();
      idle_inputs();
      expect_out("pre-rst", 1'b1, 1'b0, 1'b0, 1'b0, 32'hDEADBEEF, '0, '0, '0);
      rst = 1'b1;
      lbuf_wen = 1'b1; lbuf_waddr = 12'd5; lbuf_wdata = 32'hBAD0BAD0;
      ext_req = 1'b1; ext_we = 1'b0; ext_addr = 12'd10;
      step();
      ha_s = '0; ha_e = '0; hb_s = '0; hb_e = '0;
      expect_out("in-rst", 0, 0, 0, 0, '0, '0, '0, '0);
      chk_oor("in-rst", 1'b0);
      step();
      idle_inputs();
      rst = 1'b0;
      for (int k = 1; k <= 4; k++) begin
         step();
         expect_out($sformatf("post-rst k%0d", k), 0, 0, 0, 0, '0, '0, '0, '0);
      end
      run_read(1'b0, 12'd5, 32'hDEADBEEF, 1'b0, '0, "post-rst rd5");
      run_read(1'b1, 12'd0, 32'h00000010, 1'b0, '0, "post-rst rd0");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/spu_lbuf_resp.md
Name: spu_lbuf_resp

Overview:
- Responder side of the SPU line-buffer (lbuf) interface: one DEPTH x DATA_WIDTH storage array behind the ren/raddr/rdata read port and wen/waddr/wdata write port that SPU kernels (layernorm, softmax, ...) drive.
- 1R1W per cycle, fixed read latency RLATENCY.
- Secondary ext port (DMA load/dump) steals idle read/write slots; SPU port always has priority.
- Sits between the SPU kernels and the top-level fmbuf/DMA.

Parameters:
- ADDR_WIDTH, 12, address width of both ports.
- DATA_WIDTH, 32, word width.
- DEPTH, 4096, number of words; must be <= 2**ADDR_WIDTH.
- RLATENCY, 1, cycles from sampled read request to data; legal 1..4.

Ports:
- core_clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- lbuf_ren  in  1  SPU read request.
- lbuf_raddr  in  ADDR_WIDTH  SPU read address, qualified by lbuf_ren.
- lbuf_rdata  out  DATA_WIDTH  SPU read data.
- lbuf_rvalid  out  1  high exactly when lbuf_rdata carries a new SPU read result.
- lbuf_wen  in  1  SPU write request.
- lbuf_waddr  in  ADDR_WIDTH  SPU write address.
- lbuf_wdata  in  DATA_WIDTH  SPU write data.
- ext_req  in  1  ext access request.
- ext_we  in  1  1 = write, 0 = read; qualified by ext_req.
- ext_addr  in  ADDR_WIDTH  ext address.
- ext_wdata  in  DATA_WIDTH  ext write data.
- ext_gnt  out  1  combinational; request accepted this cycle.
- ext_rdata  out  DATA_WIDTH  ext read data.
- ext_rvalid  out  1  ext read result valid.
- oor_err  out  1  sticky; an accepted access had address >= DEPTH.
- err_clr  in  1  clears oor_err.

Behaviour:
- Reset (synchronous, rst high at a clock edge):
  - Clears all read-pipeline valid bits.
  - lbuf_rdata = 0, ext_rdata = 0, lbuf_rvalid = 0, ext_rvalid = 0, oor_err = 0.
  - Storage contents are not reset.
  - Reads in flight when reset asserts are discarded; no valid is ever produced for them.
  - Accesses presented in the cycle rst is high are ignored.
- Read slot:
  - lbuf_ren = 1 takes the read slot.
  - Otherwise ext_req & ~ext_we takes it, and ext_gnt = 1.
- Write slot:
  - lbuf_wen = 1 takes the write slot.
  - Otherwise ext_req & ext_we takes it, and ext_gnt = 1.
- ext_gnt = ext_req & (ext_we ? ~lbuf_wen : ~lbuf_ren).
  - A non-granted ext request must be held stable by the requester until granted.
- Read latency:
  - Storage is read at the request edge into stage 1; RLATENCY-1 further register stages follow.
  - Data and valid appear exactly RLATENCY cycles after the request cycle.
  - Back-to-back reads give one result per cycle, in order.
  - The pipeline carries a source tag (spu/ext), so rvalid is steered to the correct port.
- Data hold: lbuf_rdata / ext_rdata hold their last result when their valid is low; they never show the other port's data.
- Read/write collision: a same-cycle read and write to the same address returns the OLD word (read-first). The write is visible to reads issued from the next cycle on.
- Out of range (address >= DEPTH):
  - The write is dropped.
  - The read still produces its valid with data 0.
  - oor_err is set the cycle after the access.
  - err_clr clears oor_err. If err_clr and a new violation occur in the same cycle, set wins.
- No other state machine: the only sequential state is the pipeline and the error flag. Throughput is 1 read + 1 write per cycle total, shared between the two ports.

Decomposition:
- Shared package spu_lbuf_pkg: source tag constants SRC_SPU = 1'b0, SRC_EXT = 1'b1, and the legal RLATENCY range check constant.
- One natural sub-module, spu_lbuf_rd_pipe: parameterised RLATENCY shift pipeline of {valid, src, data} with synchronous clear.
- Storage is inferred inside the top as a plain array.

Test Plan:
- Reset with RLATENCY=1: write 0xDEADBEEF @5, then read @5 the next cycle -> lbuf_rdata = 0xDEADBEEF with lbuf_rvalid one cycle later; ext_rvalid stays 0.
- RLATENCY=3: four back-to-back reads @0..3 (preloaded 0x10..0x13) -> lbuf_rvalid high for 4 consecutive cycles starting 3 cycles after the first ren, data 0x10, 0x11, 0x12, 0x13 in order.
- Same-cycle write 0xAAAA and read of @7 holding 0x5555 -> read returns 0x5555; a read the next cycle returns 0xAAAA.
- ext read held during 3 cycles of lbuf_ren -> ext_gnt low for those 3 cycles, high on the 4th; ext_rvalid appears RLATENCY cycles later with the correct word; the lbuf_rdata value does not change.
- DEPTH=1024: write @1100 then read @1100 -> write dropped, read returns 0 with valid, oor_err = 1; err_clr -> oor_err = 0 next cycle.
- rst asserted one cycle after ren with RLATENCY=2 -> no lbuf_rvalid pulse ever appears; outputs are 0; post-reset reads return the pre-reset written data.
